object_kinematics: RTL and testbench

OBJECT_KINEMATICS -- requirements
Module: object_kinematics

---
 rtl/kin_pkg.sv | 17 +
 rtl/axis_step.sv | 57 +++++
 rtl/object_kinematics.sv | 166 ++++++++++++++++
 tb/tb_object_kinematics.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kin_pkg.sv
// rtl/kin_pkg.sv - shared state, mode and scan-code encodings for object_kinematics
package kin_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FLY  = 1'b1
    } kin_state_e;

    localparam int MODE_BOUNCE = 0;
    localparam int MODE_FALL   = 1;

    localparam logic [7:0] KEY_UP    = 8'h1D;
    localparam logic [7:0] KEY_DOWN  = 8'h1B;
    localparam logic [7:0] KEY_LEFT  = 8'h1C;
    localparam logic [7:0] KEY_RIGHT = 8'h23;

endpackage

// File: rtl/axis_step.sv
// rtl/axis_step.sv - one axis of motion: add velocity, clamp to [0, LIM-size], reflect or flag exit
module axis_step #(
    parameter int PW  = 10,
    parameter int VW  = 6,
    parameter int AW  = 12,
    parameter int LIM = 640
) (
    input  logic        [PW-1:0] pos_i,
    input  logic signed [VW-1:0] vel_i,
    input  logic        [PW-1:0] size_i,
    input  logic                 hi_exit_i,
    output logic        [PW-1:0] pos_o,
    output logic signed [VW-1:0] vel_o,
    output logic                 reflect_o,
    output logic                 exit_o
);

    localparam logic signed [VW-1:0] VMAX = {1'b0, {(VW-1){1'b1}}};
    localparam logic signed [VW-1:0] VMIN = {1'b1, {(VW-1){1'b0}}};

    logic signed [AW-1:0] nxt;
    logic signed [AW:0]   nxt_ext;
    logic signed [AW:0]   nxt_end;
    logic signed [AW:0]   size_s;
    logic signed [AW:0]   lim;
    logic signed [AW:0]   hi_pos;
    logic signed [VW-1:0] neg_vel;

    assign nxt     = $signed({{(AW-PW){1'b0}}, pos_i}) + $signed({{(AW-VW){vel_i[VW-1]}}, vel_i});
    assign nxt_ext = {nxt[AW-1], nxt};
    assign size_s  = $signed({{(AW+1-PW){1'b0}}, size_i});
    assign lim     = (AW+1)'(LIM);
    assign nxt_end = nxt_ext + size_s;
    // An object at least as large as the screen is pinned to the origin.
    assign hi_pos  = (size_s >= lim) ? '0 : lim - size_s;
    // Negating the most-negative code would wrap; saturate instead.
    assign neg_vel = (vel_i == VMIN) ? VMAX : -vel_i;

    always_comb begin
        pos_o     = nxt[PW-1:0];
        vel_o     = vel_i;
        reflect_o = 1'b0;
        exit_o    = 1'b0;
        if (nxt[AW-1]) begin
            pos_o     = '0;
            vel_o     = neg_vel;
            reflect_o = 1'b1;
        end else if (hi_exit_i) begin
            exit_o = (nxt_ext >= lim);
        end else if (nxt_end > lim) begin
            pos_o     = hi_pos[PW-1:0];
            vel_o     = neg_vel;
            reflect_o = 1'b1;
        end
    end

endmodule

// File: rtl/object_kinematics.sv
// rtl/object_kinematics.sv - launched object with gravity, edge bounce/exit and keyboard steering
module object_kinematics
    import kin_pkg::*;
#(
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int VW    = 6,
    parameter int SCR_W = 640,
    parameter int SCR_H = 480,
    parameter int GRAV  = 1,
    parameter int MODE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 move_tick,
    input  logic                 launch_valid,
    output logic                 launch_ready,
    input  logic        [XW-1:0] launch_x,
    input  logic        [YW-1:0] launch_y,
    input  logic signed [VW-1:0] launch_vx,
    input  logic signed [VW-1:0] launch_vy,
    input  logic        [XW-1:0] obj_w,
    input  logic        [YW-1:0] obj_h,
    input  logic                 key_valid,
    input  logic        [7:0]    key_code,
    output logic        [XW-1:0] pos_x,
    output logic        [YW-1:0] pos_y,
    output logic signed [VW-1:0] vel_x,
    output logic signed [VW-1:0] vel_y,
    output logic                 active,
    output logic                 bounce,
    output logic                 exited
);

    localparam int AW     = ((XW > YW) ? XW : YW) + 2;
    localparam int VMAX_I = (1 << (VW-1)) - 1;
    localparam logic signed [VW-1:0] VMAX = {1'b0, {(VW-1){1'b1}}};
    localparam logic signed [VW-1:0] VMIN = {1'b1, {(VW-1){1'b0}}};
    localparam logic signed [VW-1:0] VNEG = {1'b1, {(VW-2){1'b0}}, 1'b1};

    kin_state_e           state_q, state_d;
    logic        [XW-1:0] pos_x_q, pos_x_d;
    logic        [YW-1:0] pos_y_q, pos_y_d;
    logic signed [VW-1:0] vel_x_q, vel_x_d;
    logic signed [VW-1:0] vel_y_q, vel_y_d;
    logic                 bounce_q, bounce_d;
    logic                 exited_q, exited_d;

    logic        [XW-1:0] x_pos;
    logic        [YW-1:0] y_pos;
    logic signed [VW-1:0] x_vel, y_vel, vy_grav, vx_t, vy_t;
    logic                 x_refl, y_refl, x_exit, y_exit;
    logic signed [31:0]   vy_wide;

    function automatic logic signed [VW-1:0] abs_sat(input logic signed [VW-1:0] v);
        if (v == VMIN) return VMAX;
        if (v[VW-1])   return -v;
        return v;
    endfunction

    axis_step #(.PW(XW), .VW(VW), .AW(AW), .LIM(SCR_W)) u_axis_x (
        .pos_i     (pos_x_q),
        .vel_i     (vel_x_q),
        .size_i    (obj_w),
        .hi_exit_i (1'b0),
        .pos_o     (x_pos),
        .vel_o     (x_vel),
        .reflect_o (x_refl),
        .exit_o    (x_exit)
    );

    axis_step #(.PW(YW), .VW(VW), .AW(AW), .LIM(SCR_H)) u_axis_y (
        .pos_i     (pos_y_q),
        .vel_i     (vel_y_q),
        .size_i    (obj_h),
        .hi_exit_i (MODE == MODE_FALL),
        .pos_o     (y_pos),
        .vel_o     (y_vel),
        .reflect_o (y_refl),
        .exit_o    (y_exit)
    );

    assign vy_wide = 32'(vel_y_q) + GRAV;
    assign vy_grav = (vy_wide > VMAX_I)  ? VMAX :
                     (vy_wide < -VMAX_I) ? VNEG : $signed(vy_wide[VW-1:0]);

    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        vel_x_d  = vel_x_q;
        vel_y_d  = vel_y_q;
        bounce_d = 1'b0;
        exited_d = 1'b0;
        vx_t     = vel_x_q;
        vy_t     = vel_y_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_valid) begin
                    pos_x_d = launch_x;
                    pos_y_d = launch_y;
                    vel_x_d = launch_vx;
                    vel_y_d = launch_vy;
                    state_d = ST_FLY;
                end
            end
            ST_FLY: begin
                if (move_tick && (x_exit || y_exit)) begin
                    state_d  = ST_IDLE;
                    exited_d = 1'b1;
                end else begin
                    if (move_tick) begin
                        pos_x_d  = x_pos;
                        pos_y_d  = y_pos;
                        vx_t     = x_vel;
                        // A reflection on y replaces the gravity update for that tick.
                        vy_t     = y_refl ? y_vel : vy_grav;
                        bounce_d = x_refl | y_refl;
                    end
                    if (key_valid) begin
                        case (key_code)
                            KEY_UP:    vy_t = -abs_sat(vy_t);
                            KEY_DOWN:  vy_t = abs_sat(vy_t);
                            KEY_LEFT:  vx_t = -abs_sat(vx_t);
                            KEY_RIGHT: vx_t = abs_sat(vx_t);
                            default:   ;
                        endcase
                    end
                    vel_x_d = vx_t;
                    vel_y_d = vy_t;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            vel_x_q  <= '0;
            vel_y_q  <= '0;
            bounce_q <= 1'b0;
            exited_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            vel_x_q  <= vel_x_d;
            vel_y_q  <= vel_y_d;
            bounce_q <= bounce_d;
            exited_q <= exited_d;
        end
    end

    assign launch_ready = (state_q == ST_IDLE);
    assign active       = (state_q == ST_FLY);
    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign vel_x        = vel_x_q;
    assign vel_y        = vel_y_q;
    assign bounce       = bounce_q;
    assign exited       = exited_q;

endmodule

// File: tb/tb_object_kinematics.sv
// tb/tb_object_kinematics.sv - bench for object_kinematics in BOUNCE (dut 0) and FALL (dut 1) modes
module tb_object_kinematics;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              move_tick = 1'b0, launch_valid = 1'b0, key_valid = 1'b0;
    logic        [9:0] launch_x = '0, obj_w = 10'd16;
    logic        [8:0] launch_y = '0, obj_h = 9'd16;
    logic signed [5:0] launch_vx = '0, launch_vy = '0;
    logic        [7:0] key_code = '0;

    logic              ready0, active0, bounce0, exited0;
    logic        [9:0] pos_x0;
    logic        [8:0] pos_y0;
    logic signed [5:0] vel_x0, vel_y0;
    logic              ready1, active1, bounce1, exited1;
    logic        [9:0] pos_x1;
    logic        [8:0] pos_y1;
    logic signed [5:0] vel_x1, vel_y1;

    object_kinematics #(.MODE(0)) dut0 (
        .clk(clk), .rst(rst), .move_tick(move_tick),
        .launch_valid(launch_valid), .launch_ready(ready0),
        .launch_x(launch_x), .launch_y(launch_y), .launch_vx(launch_vx), .launch_vy(launch_vy),
        .obj_w(obj_w), .obj_h(obj_h), .key_valid(key_valid), .key_code(key_code),
        .pos_x(pos_x0), .pos_y(pos_y0), .vel_x(vel_x0), .vel_y(vel_y0),
        .active(active0), .bounce(bounce0), .exited(exited0)
    );

    object_kinematics #(.MODE(1)) dut1 (
        .clk(clk), .rst(rst), .move_tick(move_tick),
        .launch_valid(launch_valid), .launch_ready(ready1),
        .launch_x(launch_x), .launch_y(launch_y), .launch_vx(launch_vx), .launch_vy(launch_vy),
        .obj_w(obj_w), .obj_h(obj_h), .key_valid(key_valid), .key_code(key_code),
        .pos_x(pos_x1), .pos_y(pos_y1), .vel_x(vel_x1), .vel_y(vel_y1),
        .active(active1), .bounce(bounce1), .exited(exited1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one entry per mode, plain integer arithmetic.
    int mx[2], my[2], mvx[2], mvy[2];
    bit mact[2], mb[2], me[2];

    function automatic int sat(input int v);
        if (v > 31)  return 31;
        if (v < -31) return -31;
        return v;
    endfunction

    function automatic int absv(input int v);
        return sat(v < 0 ? -v : v);
    endfunction

    task automatic model_step(input int m);
        int nx, ny, x, y, vx, vy, w, h;
        bit ex;
        w = int'(obj_w);
        h = int'(obj_h);
        mb[m] = 0;
        me[m] = 0;
        if (rst) begin
            mx[m] = 0; my[m] = 0; mvx[m] = 0; mvy[m] = 0; mact[m] = 0;
            return;
        end
        if (!mact[m]) begin
            if (launch_valid) begin
                mx[m] = int'(launch_x); my[m] = int'(launch_y);
                mvx[m] = int'(launch_vx); mvy[m] = int'(launch_vy);
                mact[m] = 1;
            end
            return;
        end
        x = mx[m]; y = my[m]; vx = mvx[m]; vy = mvy[m]; ex = 0;
        if (move_tick) begin
            nx = mx[m] + mvx[m];
            ny = my[m] + mvy[m];
            if (nx < 0) begin
                x = 0; vx = sat(-mvx[m]); mb[m] = 1;
            end else if (nx + w > 640) begin
                x = (w >= 640) ? 0 : 640 - w; vx = sat(-mvx[m]); mb[m] = 1;
            end else x = nx;
            if (ny < 0) begin
                y = 0; vy = sat(-mvy[m]); mb[m] = 1;
            end else if (m == 0 && ny + h > 480) begin
                y = (h >= 480) ? 0 : 480 - h; vy = sat(-mvy[m]); mb[m] = 1;
            end else if (m == 1 && ny >= 480) begin
                ex = 1;
            end else begin
                y = ny; vy = sat(mvy[m] + 1);
            end
        end
        if (ex) begin
            me[m] = 1; mb[m] = 0; mact[m] = 0;
            return;
        end
        if (key_valid) begin
            case (key_code)
                8'h1D: vy = -absv(vy);
                8'h1B: vy = absv(vy);
                8'h1C: vx = -absv(vx);
                8'h23: vx = absv(vx);
                default: ;
            endcase
        end
        mx[m] = x; my[m] = y; mvx[m] = vx; mvy[m] = vy;
    endtask

    function automatic logic [34:0] exp_pack(input int m);
        return {mact[m], ~mact[m], mb[m], me[m], 10'(mx[m]), 9'(my[m]), 6'(mvx[m]), 6'(mvy[m])};
    endfunction

    task automatic cyc();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        rst = 1'b0; move_tick = 1'b0; key_valid = 1'b0; launch_valid = 1'b0;
    endtask

    task automatic launch(input int x, input int y, input int vx, input int vy);
        launch_x = 10'(x); launch_y = 9'(y); launch_vx = 6'(vx); launch_vy = 6'(vy);
        launch_valid = 1'b1;
        move_tick = 1'b1;
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; move_tick = 1'b1; launch_valid = 1'b1; key_valid = 1'b1; key_code = 8'h1D;
        cyc();
        cyc();
        n_tests++;
        if ({active0, ready0, bounce0, exited0, pos_x0, pos_y0, vel_x0, vel_y0} !== {4'b0100, 31'd0}) begin
            n_fail++;
            $display("FAIL reset_dut0: got a=%b r=%b b=%b e=%b x=%0d y=%0d vx=%0d vy=%0d, want idle zeros",
                     active0, ready0, bounce0, exited0, pos_x0, pos_y0, vel_x0, vel_y0);
        end
        n_tests++;
        if ({active1, ready1, bounce1, exited1, pos_x1, pos_y1, vel_x1, vel_y1} !== {4'b0100, 31'd0}) begin
            n_fail++;
            $display("FAIL reset_dut1: got a=%b r=%b x=%0d y=%0d", active1, ready1, pos_x1, pos_y1);
        end
    endtask

    task automatic test_launch_tick();
        do_reset();
        obj_w = 10'd16; obj_h = 9'd16;
        launch(100, 50, 3, -4);
        n_tests++;
        if (pos_x0 !== 10'd100 || pos_y0 !== 9'd50 || active0 !== 1'b1 || ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL launch_load: got x=%0d y=%0d a=%b r=%b, want 100 50 1 0", pos_x0, pos_y0, active0, ready0);
        end
        move_tick = 1'b1;
        cyc();
        n_tests++;
        if (pos_x0 !== 10'd103 || pos_y0 !== 9'd46 || vel_x0 !== 6'sd3 || vel_y0 !== -6'sd3 || bounce0 !== 1'b0) begin
            n_fail++;
            $display("FAIL first_tick: got x=%0d y=%0d vx=%0d vy=%0d b=%b, want 103 46 3 -3 0",
                     pos_x0, pos_y0, vel_x0, vel_y0, bounce0);
        end
    endtask

    task automatic test_right_edge();
        do_reset();
        obj_w = 10'd16; obj_h = 9'd16;
        launch(630, 100, 5, 0);
        move_tick = 1'b1;
        cyc();
        n_tests++;
        if (pos_x0 !== 10'd624 || vel_x0 !== -6'sd5 || bounce0 !== 1'b1) begin
            n_fail++;
            $display("FAIL right_edge: got x=%0d vx=%0d b=%b, want 624 -5 1", pos_x0, vel_x0, bounce0);
        end
        cyc();
        n_tests++;
        if (bounce0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_pulse_width: got b=%b, want 0", bounce0);
        end
    endtask

    task automatic test_fall_exit();
        do_reset();
        obj_w = 10'd16; obj_h = 9'd16;
        launch(100, 470, 0, 12);
        move_tick = 1'b1;
        cyc();
        n_tests++;
        if (exited1 !== 1'b1 || active1 !== 1'b0 || ready1 !== 1'b1 || pos_y1 !== 9'd470 || vel_y1 !== 6'sd12) begin
            n_fail++;
            $display("FAIL fall_exit: got e=%b a=%b r=%b y=%0d vy=%0d, want 1 0 1 470 12",
                     exited1, active1, ready1, pos_y1, vel_y1);
        end
        cyc();
        n_tests++;
        if (exited1 !== 1'b0) begin
            n_fail++;
            $display("FAIL exit_pulse_width: got e=%b, want 0", exited1);
        end
    endtask

    task automatic test_vy_saturate();
        do_reset();
        launch(100, 100, 0, 31);
        move_tick = 1'b1;
        cyc();
        n_tests++;
        if (vel_y0 !== 6'sd31 || pos_y0 !== 9'd131) begin
            n_fail++;
            $display("FAIL vy_saturate: got vy=%0d y=%0d, want 31 131", vel_y0, pos_y0);
        end
    endtask

    task automatic test_key_tick();
        do_reset();
        launch(100, 100, 0, 5);
        move_tick = 1'b1; key_valid = 1'b1; key_code = 8'h1D;
        cyc();
        n_tests++;
        if (vel_y0 !== -6'sd6 || pos_y0 !== 9'd105) begin
            n_fail++;
            $display("FAIL key_with_tick: got vy=%0d y=%0d, want -6 105", vel_y0, pos_y0);
        end
        key_valid = 1'b1; key_code = 8'h1C;
        cyc();
        n_tests++;
        if (vel_x0 !== 6'sd0) begin
            n_fail++;
            $display("FAIL key_zero_vx: got vx=%0d, want 0", vel_x0);
        end
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        obj_w = 10'd16;
        launch(630, 100, 5, 3);
        rst = 1'b1; move_tick = 1'b1; key_valid = 1'b1; key_code = 8'h1B; launch_valid = 1'b1;
        cyc();
        n_tests++;
        if ({active0, ready0, bounce0, exited0, pos_x0, pos_y0, vel_x0, vel_y0} !== {4'b0100, 31'd0} ||
            {active1, ready1, bounce1, exited1} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_in_flight: got a=%b r=%b b=%b e=%b x=%0d y=%0d, want idle zeros",
                     active0, ready0, bounce0, exited0, pos_x0, pos_y0);
        end
    endtask

    task automatic test_random();
        logic [7:0] codes [6];
        codes = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h00, 8'h1E};
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            obj_w = (blk == 3) ? 10'd700 : 10'($urandom_range(1, 40));
            obj_h = 9'($urandom_range(1, 40));
            for (int c = 0; c < 600; c++) begin
                launch_valid = ($urandom_range(0, 3) == 0);
                launch_x  = 10'($urandom_range(0, 639));
                launch_y  = 9'($urandom_range(0, 479));
                launch_vx = 6'($urandom_range(0, 62) - 31);
                launch_vy = 6'($urandom_range(0, 62) - 31);
                move_tick = ($urandom_range(0, 1) == 1);
                key_valid = ($urandom_range(0, 4) == 0);
                key_code  = ($urandom_range(0, 7) == 7) ? 8'($urandom) : codes[$urandom_range(0, 5)];
                cyc();
                n_tests++;
                if ({active0, ready0, bounce0, exited0, pos_x0, pos_y0, vel_x0, vel_y0} !== exp_pack(0)) begin
                    n_fail++;
                    $display("FAIL random_bounce blk=%0d c=%0d: got %h, want %h", blk, c,
                             {active0, ready0, bounce0, exited0, pos_x0, pos_y0, vel_x0, vel_y0}, exp_pack(0));
                end
                n_tests++;
                if ({active1, ready1, bounce1, exited1, pos_x1, pos_y1, vel_x1, vel_y1} !== exp_pack(1)) begin
                    n_fail++;
                    $display("FAIL random_fall blk=%0d c=%0d: got %h, want %h", blk, c,
                             {active1, ready1, bounce1, exited1, pos_x1, pos_y1, vel_x1, vel_y1}, exp_pack(1));
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_launch_tick();
        test_right_edge();
        test_fall_exit();
        test_vy_saturate();
        test_key_tick();
        test_reset_in_flight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
